sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluator for the VGA sprite engine (25 MHz pixel clock, 640x480).
- On each line-start pulse, issued during horizontal blanking, it scans the sprite attribute table in index order.
- It selects up to MAX_PER_LINE sprites that intersect the next scanline and writes them into the line renderer's slot registers.
- It sequences the attribute RAM read port and flags per-line overflow.

Parameters:
- NUM_SPRITES, 8, number of entries in the attribute table (power of two, 2..64).
- MAX_PER_LINE, 4, number of renderer slots per line (power of two, 1..8).
- SPRITE_H, 16, sprite height in lines (1..64).
- COORD_W, 10, width of line and X/Y coordinates.

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Line_Start  in  1  one-cycle pulse that starts a scan.
- i_Line  in  COORD_W  next scanline number; sampled on i_Line_Start.
- o_Attr_Rd  out  1  attribute RAM read strobe.
- o_Attr_Addr  out  clog2(NUM_SPRITES)  attribute entry index.
- i_Attr_En  in  1  sprite enable; valid the cycle after o_Attr_Rd.
- i_Attr_Y  in  COORD_W  sprite top row; valid the cycle after o_Attr_Rd.
- i_Attr_X  in  COORD_W  sprite left column; valid the cycle after o_Attr_Rd.
- o_Slot_Wr  out  1  slot write strobe.
- o_Slot_Idx  out  clog2(MAX_PER_LINE)  destination slot.
- o_Slot_Sprite  out  clog2(NUM_SPRITES)  selected sprite index.
- o_Slot_Row  out  clog2(SPRITE_H)  row within the sprite.
- o_Slot_X  out  COORD_W  sprite X position.
- o_Busy  out  1  scan in progress.
- o_Done  out  1  one-cycle pulse at scan completion.
- o_Count  out  clog2(MAX_PER_LINE)+1  sprites selected this line.
- o_Overflow  out  1  more than MAX_PER_LINE sprites hit this line.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - o_Attr_Rd, o_Slot_Wr, o_Busy, o_Done, o_Overflow = 0.
  - o_Count, o_Attr_Addr, o_Slot_* = 0.
- FSM states: IDLE, READ, EVAL, DONE.
- IDLE:
  - On i_Line_Start: latch i_Line; clear index, o_Count and o_Overflow; go to READ.
- READ:
  - Assert o_Attr_Rd for one cycle with o_Attr_Addr = index; go to EVAL.
- EVAL (RAM data valid this cycle):
  - diff = (line - i_Attr_Y) mod 2^COORD_W.
  - hit = i_Attr_En && diff < SPRITE_H. Wrap is intentional: Y=1020 covers lines 1020..1023 and 0..11.
  - Hit with count < MAX_PER_LINE: pulse o_Slot_Wr with o_Slot_Idx = count, o_Slot_Sprite = index, o_Slot_Row = diff[low bits], o_Slot_X = i_Attr_X; count += 1.
  - Hit with count == MAX_PER_LINE: set o_Overflow; go to DONE. Scan stops early.
  - Otherwise, if index == NUM_SPRITES-1, go to DONE; else index += 1 and go to READ.
- DONE:
  - Pulse o_Done for one cycle; go to IDLE.
  - o_Count and o_Overflow hold until the next i_Line_Start.
- o_Busy = 1 in READ, EVAL and DONE.
- Priority: lower index wins; slots are filled in ascending sprite order.
- Latency: worst case is 2*NUM_SPRITES+1 cycles from i_Line_Start to o_Done (17 cycles at default). This must stay below 160 hblank cycles.
- i_Line_Start while busy:
  - Abort the current scan and restart with the new line.
  - No o_Done for the aborted scan.
  - Slots already written are left as-is and are overwritten by the new scan.
- i_Line_Start in the DONE cycle: o_Done still pulses, and the new scan starts the next cycle.
- Reset mid-scan: immediately return to the reset values above.

Optional Feature:
- Macro: SPRITE_SCHED_OVERFLOW_STATS_EN.
- With the macro defined, add these ports:
  - o_Ovf_Lines out 10: saturating count of overflowed lines in the current frame.
  - i_Frame_Start in 1: on its pulse, o_Ovf_Lines is copied to o_Ovf_Last out 10 and the count is cleared.
  - o_Ovf_Lines increments on each DONE with o_Overflow=1, and saturates at 1023.
  - Both new outputs reset to 0.
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Only sprite 3 enabled, Y=100, X=200; line 107 -> one o_Slot_Wr with Idx=0, Sprite=3, Row=7, X=200; o_Count=1; o_Done 17 cycles after start; o_Overflow=0.
- Line 116 with sprite at Y=100 (diff=16) -> no write; o_Count=0; o_Done pulses.
- All 8 sprites enabled, Y=50; line 60 -> slots 0..3 written with sprites 0..3; o_Overflow=1 on the sprite-4 evaluation; o_Done 11 cycles after start; o_Count=4.
- Sprite 0 with Y=1020; line 5 -> hit with Row=9. Sprite 0 disabled, same Y -> no write.
- i_Line_Start again 6 cycles into a scan with a new line -> first scan yields no o_Done; o_Attr_Addr restarts at 0; one o_Done follows for the new line.
- i_Rst_L low mid-EVAL -> all outputs 0 asynchronously; after release the block idles until i_Line_Start. With SPRITE_SCHED_OVERFLOW_STATS_EN: 3 overflowed lines then i_Frame_Start -> o_Ovf_Last=3, o_Ovf_Lines=0.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans the attribute table and loads up to MAX_PER_LINE hits into renderer slots.
// Optional overflow statistics are enabled by defining SPRITE_SCHED_OVERFLOW_STATS_EN.
module sprite_line_scheduler #(
   parameter int NUM_SPRITES  = 8,
   parameter int MAX_PER_LINE = 4,
   parameter int SPRITE_H     = 16,
   parameter int COORD_W      = 10,
   localparam int AW = $clog2(NUM_SPRITES),
   localparam int IW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1,
   localparam int CW = $clog2(MAX_PER_LINE) + 1,
   localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic               i_Line_Start,
   input  logic [COORD_W-1:0] i_Line,
   output logic               o_Attr_Rd,
   output logic [AW-1:0]      o_Attr_Addr,
   input  logic               i_Attr_En,
   input  logic [COORD_W-1:0] i_Attr_Y,
   input  logic [COORD_W-1:0] i_Attr_X,
   output logic               o_Slot_Wr,
   output logic [IW-1:0]      o_Slot_Idx,
   output logic [AW-1:0]      o_Slot_Sprite,
   output logic [RW-1:0]      o_Slot_Row,
   output logic [COORD_W-1:0] o_Slot_X,
   output logic               o_Busy,
   output logic               o_Done,
   output logic [CW-1:0]      o_Count,
`ifdef SPRITE_SCHED_OVERFLOW_STATS_EN
   output logic [9:0]         o_Ovf_Lines,
   output logic [9:0]         o_Ovf_Last,
   input  logic               i_Frame_Start,
`endif
   output logic               o_Overflow
);

   typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] line_q;
   logic [AW-1:0]      index_q, index_d;
   logic [CW-1:0]      count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [COORD_W-1:0] diff;
   logic               hit;

   // Unsigned modular difference makes sprites near the bottom wrap onto the top lines.
   assign diff = line_q - i_Attr_Y;
   assign hit  = i_Attr_En && (diff < COORD_W'(SPRITE_H));

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= IDLE;
         line_q  <= '0;
         index_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (i_Line_Start) line_q <= i_Line;
      end
   end

   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      count_d       = count_q;
      ovf_d         = ovf_q;
      o_Slot_Wr     = 1'b0;
      o_Slot_Idx    = '0;
      o_Slot_Sprite = '0;
      o_Slot_Row    = '0;
      o_Slot_X      = '0;
      case (state_q)
         IDLE: state_d = IDLE;
         READ: state_d = EVAL;
         EVAL: begin
            if (hit && count_q == CW'(MAX_PER_LINE)) begin
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               if (hit) begin
                  o_Slot_Wr     = 1'b1;
                  o_Slot_Idx    = count_q[IW-1:0];
                  o_Slot_Sprite = index_q;
                  o_Slot_Row    = diff[RW-1:0];
                  o_Slot_X      = i_Attr_X;
                  count_d       = count_q + 1'b1;
               end
               if (index_q == AW'(NUM_SPRITES - 1)) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = READ;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A new line start in any state restarts the scan; an EVAL in progress is dropped.
      if (i_Line_Start) begin
         state_d   = READ;
         index_d   = '0;
         count_d   = '0;
         ovf_d     = 1'b0;
         o_Slot_Wr = 1'b0;
      end
   end

   assign o_Attr_Rd   = (state_q == READ);
   assign o_Attr_Addr = index_q;
   assign o_Busy      = (state_q != IDLE);
   assign o_Done      = (state_q == DONE);
   assign o_Count     = count_q;
   assign o_Overflow  = ovf_q;

`ifdef SPRITE_SCHED_OVERFLOW_STATS_EN
   logic [9:0] ovf_lines_q, ovf_last_q;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         ovf_lines_q <= '0;
         ovf_last_q  <= '0;
      end else if (i_Frame_Start) begin
         ovf_last_q  <= ovf_lines_q;
         ovf_lines_q <= '0;
      end else if (state_q == DONE && ovf_q && ovf_lines_q != 10'd1023) begin
         ovf_lines_q <= ovf_lines_q + 10'd1;
      end
   end

   assign o_Ovf_Lines = ovf_lines_q;
   assign o_Ovf_Last  = ovf_last_q;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: attribute RAM model, slot-write monitor, expected-write queue.
// Also exercises the overflow statistics when SPRITE_SCHED_OVERFLOW_STATS_EN is defined.
module tb_sprite_line_scheduler;
   localparam int W = 19;   // {slot idx[2], sprite[3], row[4], x[10]}

   logic       i_Clk = 1'b0;
   logic       i_Rst_L;
   logic       i_Line_Start;
   logic [9:0] i_Line;
   logic       o_Attr_Rd;
   logic [2:0] o_Attr_Addr;
   logic       i_Attr_En;
   logic [9:0] i_Attr_Y, i_Attr_X;
   logic       o_Slot_Wr;
   logic [1:0] o_Slot_Idx;
   logic [2:0] o_Slot_Sprite;
   logic [3:0] o_Slot_Row;
   logic [9:0] o_Slot_X;
   logic       o_Busy, o_Done, o_Overflow;
   logic [2:0] o_Count;
`ifdef SPRITE_SCHED_OVERFLOW_STATS_EN
   logic [9:0] o_Ovf_Lines, o_Ovf_Last;
   logic       i_Frame_Start;
`endif

   sprite_line_scheduler dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Line_Start(i_Line_Start), .i_Line(i_Line),
      .o_Attr_Rd(o_Attr_Rd), .o_Attr_Addr(o_Attr_Addr), .i_Attr_En(i_Attr_En),
      .i_Attr_Y(i_Attr_Y), .i_Attr_X(i_Attr_X), .o_Slot_Wr(o_Slot_Wr),
      .o_Slot_Idx(o_Slot_Idx), .o_Slot_Sprite(o_Slot_Sprite), .o_Slot_Row(o_Slot_Row),
      .o_Slot_X(o_Slot_X), .o_Busy(o_Busy), .o_Done(o_Done), .o_Count(o_Count),
`ifdef SPRITE_SCHED_OVERFLOW_STATS_EN
      .o_Ovf_Lines(o_Ovf_Lines), .o_Ovf_Last(o_Ovf_Last), .i_Frame_Start(i_Frame_Start),
`endif
      .o_Overflow(o_Overflow)
   );

   // Clock / reset
   always #20 i_Clk = ~i_Clk;

   int cyc = 0;
   always @(posedge i_Clk) cyc = cyc + 1;

   // Attribute RAM model: one-cycle read latency
   logic       tbl_en[8];
   logic [9:0] tbl_y[8];
   logic [9:0] tbl_x[8];
   logic [2:0] ram_addr = '0;
   always @(posedge i_Clk) if (o_Attr_Rd) ram_addr <= o_Attr_Addr;
   assign i_Attr_En = tbl_en[ram_addr];
   assign i_Attr_Y  = tbl_y[ram_addr];
   assign i_Attr_X  = tbl_x[ram_addr];

   // Monitor
   logic [W-1:0] got_q[$];
   logic [W-1:0] exp_q[$];
   int done_cnt = 0;
   int done_cyc = 0;
   always @(negedge i_Clk) begin
      if (o_Slot_Wr) got_q.push_back({o_Slot_Idx, o_Slot_Sprite, o_Slot_Row, o_Slot_X});
      if (o_Done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // Scoreboard
   int total = 0;
   int bad   = 0;
   int start_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwr"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) chk({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   // Driver tasks
   task automatic tick();
      @(negedge i_Clk);
      #1;
   endtask

   task automatic start_line(input logic [9:0] line);
      tick();
      i_Line_Start = 1'b1;
      i_Line       = line;
      start_cyc    = cyc;
      tick();
      i_Line_Start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base);
      for (int i = 0; i < 60 && done_cnt == base; i++) tick();
      chk({tag, "_done_seen"}, (done_cnt == base + 1) ? 1 : 0, 1);
      repeat (3) tick();
   endtask

   task automatic clear_tbl();
      for (int i = 0; i < 8; i++) begin
         tbl_en[i] = 1'b0;
         tbl_y[i]  = 10'd0;
         tbl_x[i]  = 10'd0;
      end
   endtask

   function automatic logic [W-1:0] ent(input int idx, input int spr, input int row, input int x);
      logic [1:0] a; logic [2:0] b; logic [3:0] c; logic [9:0] d;
      a = idx[1:0]; b = spr[2:0]; c = row[3:0]; d = x[9:0];
      return {a, b, c, d};
   endfunction

   initial begin
      int base;
      i_Rst_L      = 1'b0;
      i_Line_Start = 1'b0;
      i_Line       = '0;
`ifdef SPRITE_SCHED_OVERFLOW_STATS_EN
      i_Frame_Start = 1'b0;
`endif
      clear_tbl();
      repeat (3) tick();
      // Reset state
      chk("rst_busy", o_Busy, 0);
      chk("rst_rd", o_Attr_Rd, 0);
      chk("rst_addr", o_Attr_Addr, 0);
      chk("rst_wr", o_Slot_Wr, 0);
      chk("rst_done", o_Done, 0);
      chk("rst_count", o_Count, 0);
      chk("rst_ovf", o_Overflow, 0);
      chk("rst_slot_x", o_Slot_X, 0);
      i_Rst_L = 1'b1;
      repeat (2) tick();

      // Single sprite 3 at Y=100, line 107 -> row 7
      tbl_en[3] = 1'b1; tbl_y[3] = 10'd100; tbl_x[3] = 10'd200;
      base = done_cnt;
      start_line(10'd107);
      exp_q.push_back(ent(0, 3, 7, 200));
      wait_done("single", base);
      chk("single_latency", done_cyc - start_cyc, 17);
      chk("single_count", o_Count, 1);
      chk("single_ovf", o_Overflow, 0);
      check_writes("single");

      // Line 116: diff = 16, just outside the sprite
      base = done_cnt;
      start_line(10'd116);
      wait_done("edge", base);
      chk("edge_count", o_Count, 0);
      chk("edge_latency", done_cyc - start_cyc, 17);
      check_writes("edge");

      // All eight at Y=50, line 60: four slots then overflow on sprite 4
      for (int i = 0; i < 8; i++) begin
         tbl_en[i] = 1'b1; tbl_y[i] = 10'd50; tbl_x[i] = 10'(i * 10 + 5);
      end
      base = done_cnt;
      start_line(10'd60);
      for (int i = 0; i < 4; i++) exp_q.push_back(ent(i, i, 10, i * 10 + 5));
      wait_done("ovf", base);
      chk("ovf_latency", done_cyc - start_cyc, 11);
      chk("ovf_count", o_Count, 4);
      chk("ovf_flag", o_Overflow, 1);
      check_writes("ovf");

      // Vertical wrap: Y=1020 on line 5 -> row 9
      clear_tbl();
      tbl_en[0] = 1'b1; tbl_y[0] = 10'd1020; tbl_x[0] = 10'd33;
      base = done_cnt;
      start_line(10'd5);
      exp_q.push_back(ent(0, 0, 9, 33));
      wait_done("wrap", base);
      chk("wrap_count", o_Count, 1);
      chk("wrap_ovf", o_Overflow, 0);
      check_writes("wrap");
      tbl_en[0] = 1'b0;
      base = done_cnt;
      start_line(10'd5);
      wait_done("wrap_dis", base);
      chk("wrap_dis_count", o_Count, 0);
      check_writes("wrap_dis");

      // Restart 6 cycles into a scan
      clear_tbl();
      tbl_en[3] = 1'b1; tbl_y[3] = 10'd100; tbl_x[3] = 10'd200;
      base = done_cnt;
      start_line(10'd107);
      repeat (5) tick();
      i_Line_Start = 1'b1;
      i_Line       = 10'd110;
      start_cyc    = cyc;
      tick();
      i_Line_Start = 1'b0;
      chk("abort_rd", o_Attr_Rd, 1);
      chk("abort_addr", o_Attr_Addr, 0);
      exp_q.push_back(ent(0, 3, 10, 200));
      wait_done("abort", base);
      chk("abort_latency", done_cyc - start_cyc, 17);
      repeat (20) tick();
      chk("abort_done_total", done_cnt - base, 1);
      chk("abort_count", o_Count, 1);
      check_writes("abort");

      // Reset asserted during an EVAL with a hit
      tbl_en[0] = 1'b1; tbl_y[0] = 10'd100; tbl_x[0] = 10'd77;
      start_line(10'd100);
      tick();
      chk("mid_eval_wr", o_Slot_Wr, 1);
      i_Rst_L = 1'b0;
      #1;
      chk("mid_rst_wr", o_Slot_Wr, 0);
      chk("mid_rst_busy", o_Busy, 0);
      chk("mid_rst_x", o_Slot_X, 0);
      chk("mid_rst_count", o_Count, 0);
      got_q.delete();
      tick();
      i_Rst_L = 1'b1;
      base = done_cnt;
      repeat (8) tick();
      chk("post_rst_busy", o_Busy, 0);
      chk("post_rst_rd", o_Attr_Rd, 0);
      chk("post_rst_done", done_cnt - base, 0);
      check_writes("post_rst");

`ifdef SPRITE_SCHED_OVERFLOW_STATS_EN
      for (int i = 0; i < 8; i++) begin
         tbl_en[i] = 1'b1; tbl_y[i] = 10'd50; tbl_x[i] = 10'd1;
      end
      for (int n = 0; n < 3; n++) begin
         base = done_cnt;
         start_line(10'd60);
         wait_done("stats", base);
         got_q.delete();
      end
      chk("stats_lines", o_Ovf_Lines, 3);
      i_Frame_Start = 1'b1;
      tick();
      i_Frame_Start = 1'b0;
      chk("stats_last", o_Ovf_Last, 3);
      chk("stats_cleared", o_Ovf_Lines, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
